// File: rtl/core_mem_lsu.sv
// Load/store unit between the EX stage and a single-outstanding memory bus.
// Handles lane steering for stores, load extraction and misalignment drops.
module core_mem_lsu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [XLEN-1:0] ex_addr,
  input  logic [XLEN-1:0] ex_wdata,
  input  logic            ex_is_load,
  input  logic            ex_is_store,
  input  logic [1:0]      ex_size,
  input  logic            ex_unsigned,
  input  logic [4:0]      ex_rd,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  output logic            mem_req_we,
  output logic [3:0]      mem_req_wstrb,
  output logic [XLEN-1:0] mem_req_wdata,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_rdata,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_misalign
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic              accept_s;
  logic              mem_op_s;
  logic              misalign_s;
  logic              issue_s;
  logic              retire_s;
  logic [3:0]        wstrb_s;
  logic [XLEN-1:0]   wdata_s;

  logic              req_valid_r;
  logic [XLEN-1:0]   req_addr_r;
  logic              req_we_r;
  logic [3:0]        req_wstrb_r;
  logic [XLEN-1:0]   req_wdata_r;
  logic [1:0]        addr_lo_r;
  logic [1:0]        size_r;
  logic              unsigned_r;
  logic [4:0]        rd_r;

  // Size 11 is reserved and always dropped as misaligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic bad;
    case (size)
      2'b00:   bad = 1'b0;
      2'b01:   bad = lo[0];
      2'b10:   bad = (lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [31:0] extract_load(input logic [31:0] rdata, input logic [1:0] size,
                                               input logic [1:0] lo, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (lo)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = lo[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      2'b00:   res = uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   res = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: res = rdata;
    endcase
    return res;
  endfunction

  assign ex_ready   = (state_r == IDLE) && !rst;
  assign accept_s   = ex_valid && ex_ready;
  assign mem_op_s   = ex_is_load || ex_is_store;
  assign misalign_s = is_misaligned(ex_size, ex_addr[1:0]);
  assign issue_s    = accept_s && mem_op_s && !misalign_s;
  assign retire_s   = (state_r == WAIT) && mem_rsp_valid;

  assign mem_req_valid = req_valid_r;
  assign mem_req_addr  = req_addr_r;
  assign mem_req_we    = req_we_r;
  assign mem_req_wstrb = req_wstrb_r;
  assign mem_req_wdata = req_wdata_r;

  // Next-state logic; responses only count while waiting for them.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (issue_s) state_nxt_s = REQ;
        else         state_nxt_s = IDLE;
      end
      REQ: begin
        if (mem_req_ready) state_nxt_s = WAIT;
        else               state_nxt_s = REQ;
      end
      WAIT: begin
        if (mem_rsp_valid) state_nxt_s = IDLE;
        else               state_nxt_s = WAIT;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_nxt_s;
  end

  // Store lane steering from the incoming op.
  always_comb begin
    wstrb_s = 4'b0000;
    wdata_s = ex_wdata;
    if (ex_is_store) begin
      case (ex_size)
        2'b00: begin
          wstrb_s = 4'b0001 << ex_addr[1:0];
          wdata_s = {4{ex_wdata[7:0]}};
        end
        2'b01: begin
          wstrb_s = 4'b0011 << {ex_addr[1], 1'b0};
          wdata_s = {2{ex_wdata[15:0]}};
        end
        2'b10: begin
          wstrb_s = 4'b1111;
          wdata_s = ex_wdata;
        end
        default: begin
          wstrb_s = 4'b0000;
          wdata_s = ex_wdata;
        end
      endcase
    end else begin
      wstrb_s = 4'b0000;
      wdata_s = ex_wdata;
    end
  end

  // Op capture at accept; fields hold until the op retires.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_valid_r <= 1'b0;
      req_addr_r  <= 32'd0;
      req_we_r    <= 1'b0;
      req_wstrb_r <= 4'b0000;
      req_wdata_r <= 32'd0;
      addr_lo_r   <= 2'd0;
      size_r      <= 2'd0;
      unsigned_r  <= 1'b0;
      rd_r        <= 5'd0;
    end else begin
      req_valid_r <= (state_nxt_s == REQ);
      if (issue_s) begin
        req_addr_r  <= {ex_addr[31:2], 2'b00};
        req_we_r    <= ex_is_store;
        req_wstrb_r <= wstrb_s;
        req_wdata_r <= wdata_s;
        addr_lo_r   <= ex_addr[1:0];
        size_r      <= ex_size;
        unsigned_r  <= ex_unsigned;
        rd_r        <= ex_rd;
      end
    end
  end

  // Writeback and misalign pulses; they come from disjoint states so never overlap.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid    <= 1'b0;
      wb_misalign <= 1'b0;
      wb_rd       <= 5'd0;
      wb_data     <= 32'd0;
    end else begin
      wb_valid    <= retire_s && !req_we_r;
      wb_misalign <= accept_s && mem_op_s && misalign_s;
      if (retire_s && !req_we_r) begin
        wb_rd   <= rd_r;
        wb_data <= extract_load(mem_rsp_rdata, size_r, addr_lo_r, unsigned_r);
      end
    end
  end

endmodule
